approx_mult_pipe: RTL and testbench
===================================

Name: approx_mult_pipe

Overview:
- Parametrised, pipelined unsigned truncated array multiplier.
- Returns the upper W bits of the W×W product.
- A per-transaction mode selects either the approximate result (low-order partial-product columns dropped) or the exact result.
- Sits between operand producers and accumulator/datapath consumers behind a valid/ready handshake; throughput is one product per cycle.

Parameters:
- W, 8, operand and result width; legal range 4..32.
- EXTRA, 2, number of kept partial-product columns below the output LSB; legal range 0..W; EXTRA=W makes approximate mode equal exact mode.
- STAGES, 2, pipeline register stages; legal range 1..W; partial-product rows are split across stages, ceil(W/STAGES) rows per stage.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_x  in  W  multiplicand, unsigned
- in_y  in  W  multiplier, unsigned
- in_exact  in  1  1 = exact mode, 0 = approximate mode; sampled with the beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_p  out  W  result, upper W bits
- out_exact  out  1  mode of the returned beat

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: all stage valid bits, out_valid, out_p and out_exact go to 0. Data registers may also clear to 0. In-flight beats are discarded; reset asserted mid-operation loses them with no partial output.
- Arithmetic, approximate mode:
  - T = sum of x_i·y_j·2^(i+j) over all i+j ≥ W−EXTRA.
  - out_p = T[2W−1:W].
  - Accumulators are 2W bits wide; no overflow is possible.
- Arithmetic, exact mode: out_p = (in_x·in_y)[2W−1:W].
- Pipeline:
  - Stage k adds its row group, masked per the beat's mode, to the running sum.
  - Operands and mode travel with the beat.
  - Latency from input acceptance to out_valid is exactly STAGES cycles when there is no stall.
- Handshake:
  - A beat is accepted on in_valid && in_ready. A result is consumed on out_valid && out_ready.
  - Global stall: advance = !out_valid || out_ready.
  - in_ready = advance. It is combinational from out_ready; it is not combinational from in_valid.
  - When advance=0, every stage register holds.
  - out_p and out_exact are stable while out_valid && !out_ready.
  - Pipeline bubbles propagate as valid=0 and never produce out_valid.
- Boundary conditions:
  - Result consumed and new beat accepted in the same cycle: both occur, no bubble inserted.
  - Full pipeline with out_ready=0: in_ready=0, and no beat is lost or duplicated.
  - in_exact may change every beat; results keep order (FIFO order, no reordering).
  - STAGES=1: single register stage, latency 1.
  - Row count not divisible by STAGES: the last stage takes the remainder rows.
- No state machine beyond the per-stage valid bits.

Optional Feature:
- APPROX_ROUND_EN defined:
  - In approximate mode only, the constant 2^(W−1) is added to T before truncation. This is round-half compensation for the dropped columns.
  - Exact mode is unaffected.
- Undefined: no compensation; approximate results are pure truncation.
- Ports, latency and handshake are identical in both builds.

Decomposition:
- Package approx_mult_pkg:
  - function col_keep(col, W, EXTRA, exact) returning the column mask bit.
  - function rows_in_stage(k, W, STAGES).
  - localparam for accumulator width 2W.
  - Mode encoding constants: MODE_APPROX=0, MODE_EXACT=1.
- Sub-module approx_pp_stage: one pipeline stage holding the valid bit, operands, mode and partial sum. It adds its row group under the column mask and honours advance. The top level instantiates it STAGES times in a generate loop and adds the handshake glue.

Test Plan:
- W=8, EXTRA=2, STAGES=2, no macro, approximate: X=0xFF, Y=0xFF → out_p=0xFC (T=0xFCC0), 2 cycles after acceptance.
- Same beat, exact mode → out_p=0xFE. With APPROX_ROUND_EN, approximate mode → out_p=0xFD.
- X=0x80, Y=0x80 in both modes → out_p=0x40. X=0x01, Y=0x01 → out_p=0x00.
- Back-to-back stream of 16 random beats with random modes, out_ready held 1 → one result per cycle, in order, each matching the reference model; in_ready never drops.
- Backpressure: hold out_ready=0 for 5 cycles with the pipeline full → in_ready=0, out_p/out_exact stable; on release, no beat is lost or duplicated.
- Assert rst_n low for 1 cycle with 2 beats in flight → out_valid=0 immediately (asynchronously), and no stale result appears after reset release.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the truncated array multiplier: mode encoding,
// accumulator sizing and the column-mask / row-split helpers.
package approx_mult_pkg;

  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT  = 1'b1;

  localparam int DEF_W     = 8;
  localparam int DEF_ACC_W = 2 * DEF_W;

  // The full product of two w-bit operands never exceeds 2w bits.
  function automatic int acc_width(input int w);
    return 2 * w;
  endfunction

  function automatic logic col_keep(input int col, input int w, input int extra,
                                    input logic exact);
    return (exact == MODE_EXACT) || (col >= (w - extra));
  endfunction

  function automatic int rows_per_stage(input int w, input int stages);
    return (w + stages - 1) / stages;
  endfunction

  function automatic int row_lo(input int k, input int w, input int stages);
    return k * rows_per_stage(w, stages);
  endfunction

  // Trailing stages may own fewer rows, or none when ceil() overshoots.
  function automatic int rows_in_stage(input int k, input int w, input int stages);
    int lo;
    int rps;
    rps = rows_per_stage(w, stages);
    lo  = k * rps;
    if (lo >= w) return 0;
    return ((w - lo) < rps) ? (w - lo) : rps;
  endfunction

endpackage

// File: rtl/approx_pp_stage.sv
// One pipeline stage: adds its group of multiplier rows, masked by the beat's
// mode, to the incoming partial sum and registers beat, operands and sum.
module approx_pp_stage
  import approx_mult_pkg::*;
#(
  parameter int W       = 8,
  parameter int EXTRA   = 2,
  parameter int ROW_LO  = 0,
  parameter int ROW_CNT = 4,
  localparam int ACC_W  = acc_width(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_advance,
  input  logic             i_vld,
  input  logic [W-1:0]     i_x,
  input  logic [W-1:0]     i_y,
  input  logic             i_exact,
  input  logic [ACC_W-1:0] i_sum,
  output logic             o_vld,
  output logic [W-1:0]     o_x,
  output logic [W-1:0]     o_y,
  output logic             o_exact,
  output logic [ACC_W-1:0] o_sum
);

  logic             r_vld;
  logic [W-1:0]     r_x;
  logic [W-1:0]     r_y;
  logic             r_exact;
  logic [ACC_W-1:0] r_sum;

  logic [ACC_W-1:0] w_x_ext;
  logic [ACC_W-1:0] w_mask;
  logic [ACC_W-1:0] w_sum_next;

  function automatic logic [ACC_W-1:0] col_mask(input logic exact);
    logic [ACC_W-1:0] m;
    m = '0;
    for (int c = 0; c < ACC_W; c++) begin
      m[c] = col_keep(c, W, EXTRA, exact);
    end
    return m;
  endfunction

  always_comb begin
    w_x_ext    = ACC_W'(i_x);
    w_mask     = col_mask(i_exact);
    w_sum_next = i_sum;
    for (int j = 0; j < W; j++) begin
      if ((j >= ROW_LO) && (j < ROW_LO + ROW_CNT) && i_y[j]) begin
        w_sum_next = w_sum_next + ((w_x_ext << j) & w_mask);
      end
    end
  end

  // stage register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_exact <= 1'b0;
      r_sum   <= '0;
    end else if (i_advance) begin
      r_vld   <= i_vld;
      r_x     <= i_x;
      r_y     <= i_y;
      r_exact <= i_exact;
      r_sum   <= w_sum_next;
    end
  end

  assign o_vld   = r_vld;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_exact = r_exact;
  assign o_sum   = r_sum;

endmodule

// File: rtl/approx_mult_pipe.sv
// Pipelined unsigned truncated multiplier returning the upper W bits of x*y,
// exact or approximate per beat. Define APPROX_ROUND_EN to add 2^(W-1)
// round-half compensation to approximate-mode results.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W      = 8,
  parameter int EXTRA  = 2,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic         in_exact,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_p,
  output logic         out_exact
);

  localparam int ACC_W = acc_width(W);

  logic             w_advance;
  logic             w_vld   [STAGES+1];
  logic [W-1:0]     w_x     [STAGES+1];
  logic [W-1:0]     w_y     [STAGES+1];
  logic             w_exact [STAGES+1];
  logic [ACC_W-1:0] w_sum   [STAGES+1];

  // Seed value of the running sum; carries the optional rounding bias.
  function automatic logic [ACC_W-1:0] init_sum(input logic exact);
    logic [ACC_W-1:0] bias;
`ifdef APPROX_ROUND_EN
    bias = ACC_W'(1) << (W - 1);
`else
    bias = '0;
`endif
    return (exact == MODE_APPROX) ? bias : '0;
  endfunction

  // Single global stall: the whole pipe moves unless the output is blocked.
  assign w_advance = !w_vld[STAGES] || out_ready;
  assign in_ready  = w_advance;

  assign w_vld[0]   = in_valid;
  assign w_x[0]     = in_x;
  assign w_y[0]     = in_y;
  assign w_exact[0] = in_exact;
  assign w_sum[0]   = init_sum(in_exact);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    approx_pp_stage #(
      .W       (W),
      .EXTRA   (EXTRA),
      .ROW_LO  (row_lo(k, W, STAGES)),
      .ROW_CNT (rows_in_stage(k, W, STAGES))
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_advance (w_advance),
      .i_vld     (w_vld[k]),
      .i_x       (w_x[k]),
      .i_y       (w_y[k]),
      .i_exact   (w_exact[k]),
      .i_sum     (w_sum[k]),
      .o_vld     (w_vld[k+1]),
      .o_x       (w_x[k+1]),
      .o_y       (w_y[k+1]),
      .o_exact   (w_exact[k+1]),
      .o_sum     (w_sum[k+1])
    );
  end

  assign out_valid = w_vld[STAGES];
  assign out_exact = w_exact[STAGES];
  assign out_p     = w_sum[STAGES][ACC_W-1:W];

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe: directed vector table, random
// streams with a column-sum reference model, backpressure and reset cases.
module tb_approx_mult_pipe;

  localparam int W      = 8;
  localparam int EXTRA  = 2;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic         in_exact = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_p;
  logic         out_exact;

  always #5 clk = ~clk;

  approx_mult_pipe #(.W(W), .EXTRA(EXTRA), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_exact  (in_exact),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_exact (out_exact)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_consumed = 0;

  typedef struct {
    logic [W-1:0] p;
    logic         e;
  } res_t;
  res_t exp_q[$];
  res_t mon_r;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         e;
    logic [W-1:0] p;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: sum every kept partial-product bit, then take the top half.
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic e);
    longint unsigned t;
    t = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (x[i] && y[j] && (e || (i + j >= W - EXTRA)))
          t += longint'(1) << (i + j);
`ifdef APPROX_ROUND_EN
    if (!e) t += longint'(1) << (W - 1);
`endif
    return W'(t >> W);
  endfunction

  // Scoreboard and hold-stability monitor.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_p = '0;
  logic         prev_e = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_p", 64'(out_p), 64'(prev_p));
        chk("hold_exact", 64'(out_exact), 64'(prev_e));
      end
      if (out_valid && out_ready) begin
        n_consumed++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_output: actual p=%0h required none", out_p);
        end else begin
          mon_r = exp_q.pop_front();
          chk("sb_out_p", 64'(out_p), 64'(mon_r.p));
          chk("sb_out_exact", 64'(out_exact), 64'(mon_r.e));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back('{p: model(in_x, in_y, in_exact), e: in_exact});
      prev_stall = out_valid && !out_ready;
      prev_p     = out_p;
      prev_e     = out_exact;
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic e);
    int waited;
    waited   = 0;
    in_x     = x;
    in_y     = y;
    in_exact = e;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: actual in_ready=0 required 1 within 100 cycles");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  int  lat;
  int  base;
  bit  drv_done;
  logic [W-1:0] hp;
  logic         he;

  initial begin
    vecs[0] = '{x: 8'hFF, y: 8'hFF, e: 1'b0,
`ifdef APPROX_ROUND_EN
                p: 8'hFD};
`else
                p: 8'hFC};
`endif
    vecs[1] = '{x: 8'hFF, y: 8'hFF, e: 1'b1, p: 8'hFE};
    vecs[2] = '{x: 8'h80, y: 8'h80, e: 1'b0, p: 8'h40};
    vecs[3] = '{x: 8'h80, y: 8'h80, e: 1'b1, p: 8'h40};
    vecs[4] = '{x: 8'h01, y: 8'h01, e: 1'b0, p: 8'h00};
    vecs[5] = '{x: 8'h01, y: 8'h01, e: 1'b1, p: 8'h00};
    vecs[6] = '{x: 8'h10, y: 8'h10, e: 1'b1, p: 8'h01};
    vecs[7] = '{x: 8'h00, y: 8'hFF, e: 1'b1, p: 8'h00};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_p", 64'(out_p), 64'd0);
    chk("rst_out_exact", 64'(out_exact), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: value and latency
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      send(vecs[k].x, vecs[k].y, vecs[k].e);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!out_valid && lat < 20);
      chk($sformatf("vec%0d_latency", k), 64'(lat), 64'(STAGES));
      chk($sformatf("vec%0d_out_p", k), 64'(out_p), 64'(vecs[k].p));
      chk($sformatf("vec%0d_out_exact", k), 64'(out_exact), 64'(vecs[k].e));
      @(posedge clk);
      #1;
    end
    drain();

    // Back-to-back stream, out_ready held high
    base = n_consumed;
    fork
      begin
        for (int i = 0; i < 16; i++)
          send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end
      begin
        for (int i = 0; i < 16 + STAGES; i++) begin
          @(negedge clk);
          if (i < 16) chk("stream_in_ready", 64'(in_ready), 64'd1);
          if (i >= STAGES) chk("stream_out_valid", 64'(out_valid), 64'd1);
        end
      end
    join
    drain();
    chk("stream_count", 64'(n_consumed - base), 64'd16);

    // Backpressure with full pipeline
    base = n_consumed;
    out_ready = 1'b0;
    send(8'hC3, 8'h5A, 1'b0);
    send(8'h7E, 8'hE7, 1'b1);
    fork
      send(8'hAB, 8'hCD, 1'b0);
      begin
        @(negedge clk);
        hp = out_p;
        he = out_exact;
        for (int i = 0; i < 5; i++) begin
          chk("bp_in_ready", 64'(in_ready), 64'd0);
          chk("bp_out_valid", 64'(out_valid), 64'd1);
          chk("bp_out_p_stable", 64'(out_p), 64'(hp));
          chk("bp_out_exact_stable", 64'(out_exact), 64'(he));
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(n_consumed - base), 64'd3);

    // Random gaps and random backpressure
    base = n_consumed;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("rand_count", 64'(n_consumed - base), 64'd40);

    // Reset with two beats in flight
    base = n_consumed;
    send(8'h99, 8'h77, 1'b1);
    send(8'h55, 8'h33, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    end
    chk("rst_consumed", 64'(n_consumed - base), 64'd0);
    @(posedge clk);
    #1;
    send(8'hFF, 8'hFF, 1'b1);
    drain();
    chk("post_rst_count", 64'(n_consumed - base), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
